truth_table_sweeper: RTL
========================

// Module: truth_table_sweeper
// PURPOSE
//  Exhaustive stimulus/capture stage around a 5-input, 2-output combinational block (x1..x5 -> f,g).
//  Drives all 32 input vectors in ascending order: x1 = MSB, x5 = LSB.
//  Captures f and g into 32-bit truth tables and checks them against expected constants.
//  Reports done/pass, error count and first failing index. Used for on-chip self-check and bench sign-off.
// PARAMETERS
//  F_EXPECT  32'hC8F5_0035  expected f truth table; bit i = f at vector i
//  G_EXPECT  32'hC8F5_0035  expected g truth table; bit i = g at vector i
//  SETTLE    1              cycles each vector is held before sampling; legal range 1..15
// PORTS
//  clk            in   1   single clock, rising edge
//  rst_n          in   1   reset, asynchronous assert, active low
//  start          in   1   begin sweep; sampled in IDLE/DONE only
//  abort          in   1   synchronous abort of a running sweep
//  x1..x5         out  1   vector bits to the logic under test; x1..x5 = idx[4:0]
//  f_in, g_in     in   1   responses of the logic under test
//  busy           out  1   sweep in progress (DRIVE or SAMPLE)
//  done           out  1   sweep completed; held until next start
//  pass           out  1   done && err_count==0
//  f_table        out  32  captured f; bit i written when vector i is sampled
//  g_table        out  32  captured g
//  err_count      out  6   number of vectors with f or g mismatch, 0..32
//  first_err_idx  out  5   index of first mismatching vector; valid when err_count!=0
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, idx=0, settle_cnt=0, all outputs 0 (x1..x5=0, tables=0).
//  All outputs are driven directly from registers; no combinational input-to-output path.
//  FSM states: IDLE, DRIVE, SAMPLE, DONE.
//  IDLE/DONE, start=1:
//   -> DRIVE next cycle; idx=0, settle_cnt=0.
//   Clear tables, err_count, first_err_idx; done=0.
//  DRIVE:
//   - x = idx; settle_cnt increments.
//   - When settle_cnt==SETTLE-1: -> SAMPLE.
//  SAMPLE:
//   - At the closing edge: f_table[idx]<=f_in, g_table[idx]<=g_in.
//   - Mismatch = (f_in!=F_EXPECT[idx]) | (g_in!=G_EXPECT[idx]).
//   - On mismatch: err_count+1; first_err_idx<=idx if err_count==0.
//   - idx==31: -> DONE, done=1. Otherwise idx+1, settle_cnt=0, -> DRIVE.
//  Vector timing: SETTLE+1 cycles per vector. Sweep = 32*(SETTLE+1) cycles of busy=1.
//  start is ignored while busy. start and abort together in IDLE/DONE: start wins.
//  abort while busy (either state):
//   -> IDLE next cycle; busy=0, done=0, x=0.
//   Partial tables/err_count retained until next start.
//  idx does not wrap: 31 is the terminal vector. err_count max is 32 and fits 6 bits, so no saturation logic.
//  rst_n low mid-sweep: immediate return to reset values; no resume.
// TESTING
//  1 Reset: rst_n=0 for 3 cycles
//    -> busy=done=pass=0, x=00000, tables=0, err_count=0.
//  2 Correct logic model, SETTLE=1, start for 1 cycle
//    -> busy for 64 cycles; x steps 0..31 every 2 cycles.
//    -> done=1, pass=1, f_table=g_table=32'hC8F50035, err_count=0.
//  3 g_in tied 0, SETTLE=2
//    -> busy for 96 cycles; g_table=0, err_count=13, first_err_idx=0, pass=0.
//  4 f_in inverted only at vector 27 (x=11011)
//    -> err_count=1, first_err_idx=27, f_table=32'hC0F50035, pass=0.
//  5 abort while idx=10
//    -> IDLE next cycle, busy=0, done=0.
//    Then start -> clean full sweep, pass=1.
//    Also: start pulses while busy do not restart or extend the sweep.
//  6 rst_n low asynchronously at idx=20
//    -> outputs 0 without waiting for a clock edge; after release, start gives a full pass sweep.

Source files
------------

// File: rtl/truth_table_sweeper_if.sv
// rtl/truth_table_sweeper_if.sv - control, vector and result signals of the truth table sweeper
// master drives start/abort and the logic-under-test responses; slave is the sweeper itself.
interface truth_table_sweeper_if;
  logic        start;
  logic        abort;
  logic        x1, x2, x3, x4, x5;
  logic        f_in;
  logic        g_in;
  logic        busy;
  logic        done;
  logic        pass;
  logic [31:0] f_table;
  logic [31:0] g_table;
  logic [5:0]  err_count;
  logic [4:0]  first_err_idx;

  modport master (
    output start, abort, f_in, g_in,
    input  x1, x2, x3, x4, x5, busy, done, pass, f_table, g_table, err_count, first_err_idx
  );

  modport slave (
    input  start, abort, f_in, g_in,
    output x1, x2, x3, x4, x5, busy, done, pass, f_table, g_table, err_count, first_err_idx
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - exhaustive 5-input sweep with f/g truth table capture and check
// Every output is a register; vector i is held SETTLE cycles in DRIVE plus one SAMPLE cycle.
module truth_table_sweeper #(
  parameter logic [31:0] F_EXPECT = 32'hC8F5_0035,
  parameter logic [31:0] G_EXPECT = 32'hC8F5_0035,
  parameter int unsigned SETTLE   = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  truth_table_sweeper_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t      state;
  logic [4:0]  idx;
  logic [3:0]  settle_cnt;
  logic [4:0]  x;
  logic        busy;
  logic        done;
  logic        pass;
  logic [31:0] f_table;
  logic [31:0] g_table;
  logic [5:0]  err_count;
  logic [4:0]  first_err_idx;
  logic        mismatch;

  assign mismatch = (bus.f_in != F_EXPECT[idx]) | (bus.g_in != G_EXPECT[idx]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      idx           <= 5'd0;
      settle_cnt    <= 4'd0;
      x             <= 5'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      f_table       <= 32'd0;
      g_table       <= 32'd0;
      err_count     <= 6'd0;
      first_err_idx <= 5'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state         <= DRIVE;
            idx           <= 5'd0;
            settle_cnt    <= 4'd0;
            x             <= 5'd0;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            f_table       <= 32'd0;
            g_table       <= 32'd0;
            err_count     <= 6'd0;
            first_err_idx <= 5'd0;
          end
        end
        DRIVE: begin
          if (bus.abort) begin
            state      <= IDLE;
            idx        <= 5'd0;
            settle_cnt <= 4'd0;
            x          <= 5'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
            if (settle_cnt == SETTLE_LAST) state <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (bus.abort) begin
            state      <= IDLE;
            idx        <= 5'd0;
            settle_cnt <= 4'd0;
            x          <= 5'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
          end else begin
            f_table[idx] <= bus.f_in;
            g_table[idx] <= bus.g_in;
            if (mismatch) begin
              err_count <= err_count + 6'd1;
              if (err_count == 6'd0) first_err_idx <= idx;
            end
            // pass is registered, so it folds in this final vector's result
            if (idx == 5'd31) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_count == 6'd0) && !mismatch;
            end else begin
              state      <= DRIVE;
              idx        <= idx + 5'd1;
              x          <= idx + 5'd1;
              settle_cnt <= 4'd0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign {bus.x1, bus.x2, bus.x3, bus.x4, bus.x5} = x;
  assign bus.busy          = busy;
  assign bus.done          = done;
  assign bus.pass          = pass;
  assign bus.f_table       = f_table;
  assign bus.g_table       = g_table;
  assign bus.err_count     = err_count;
  assign bus.first_err_idx = first_err_idx;
endmodule
